// File: rtl/serial_tile_rx.sv
// serial_tile_rx: framed LSB-first serial operand receiver.
// Reassembles W-bit elements into a row-major ROWS x COLS tile behind valid/ready.
module serial_tile_rx #(
    parameter int W    = 8,
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ser_en,
    input  logic                   ser_sync,
    input  logic                   ser_data,
    output logic [ROWS*COLS*W-1:0] tile_data,
    output logic                   tile_valid,
    input  logic                   tile_ready,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int N  = ROWS * COLS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(W - 1);
    localparam logic [IW-1:0] LAST_ELEM = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t         r_state;
    logic [W-1:0]   r_shreg;
    logic [CW-1:0]  r_bit_cnt;
    logic [IW-1:0]  r_elem_idx;
    logic [N*W-1:0] r_tile;
    logic           r_valid;
    logic           r_ferr;
    logic           r_ovf;

    logic           w_sync;
    logic           w_bit;
    logic           w_ovf_set;
    logic [W-1:0]   w_shnext;

    assign w_sync    = ser_en & ser_sync;
    assign w_bit     = ser_en & ~ser_sync;
    assign w_shnext  = {ser_data, r_shreg[W-1:1]};
    // A sync that arrives while a tile waits (and is not being accepted) is lost
    assign w_ovf_set = (r_state == FULL) & ~tile_ready & w_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_elem_idx <= '0;
            r_tile     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            if (ovf_clr)
                r_ovf <= 1'b0;
            else if (w_ovf_set)
                r_ovf <= 1'b1;

            unique case (r_state)
                IDLE: begin
                    if (w_sync) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                    end
                end
                SHIFT: begin
                    if (w_sync) begin
                        r_ferr    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                    end else if (w_bit) begin
                        r_shreg <= w_shnext;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            for (int i = 0; i < N; i++) begin
                                if (r_elem_idx == IW'(i))
                                    r_tile[i*W +: W] <= w_shnext;
                            end
                            if (r_elem_idx == LAST_ELEM) begin
                                r_elem_idx <= '0;
                                r_valid    <= 1'b1;
                                r_state    <= FULL;
                            end else begin
                                r_elem_idx <= r_elem_idx + 1'b1;
                                r_state    <= IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (tile_ready) begin
                        r_valid <= 1'b0;
                        if (w_sync) begin
                            r_state   <= SHIFT;
                            r_bit_cnt <= '0;
                            r_shreg   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tile_data  = r_tile;
    assign tile_valid = r_valid;
    assign frame_err  = r_ferr;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_tile_rx.sv
// Scoreboard bench for serial_tile_rx: stimulus pushes expected tiles,
// a negedge monitor pops and compares on every tile handshake.
module tb_serial_tile_rx;
    localparam int W    = 8;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    localparam logic [N*W-1:0] TA  = 128'hFE010004_01FF0202_0302FF00_04030201;
    localparam logic [N*W-1:0] TB  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [N*W-1:0] TE  = 128'h8F8E8D8C_8B8A8988_87867F84_83828180;
    localparam logic [N*W-1:0] TD  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [N*W-1:0] TE2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C81;
    localparam logic [N*W-1:0] TF  = 128'h66554433_22110099_88776655_44332211;
    localparam logic [N*W-1:0] TG  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    logic           clk = 1'b0;
    logic           rst;
    logic           ser_en;
    logic           ser_sync;
    logic           ser_data;
    logic [N*W-1:0] tile_data;
    logic           tile_valid;
    logic           tile_ready;
    logic           frame_err;
    logic           overflow;
    logic           ovf_clr;

    always #5 clk = ~clk;

    serial_tile_rx #(.W(W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_en     (ser_en),
        .ser_sync   (ser_sync),
        .ser_data   (ser_data),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    int             checks   = 0;
    int             errors   = 0;
    int             cyc      = 0;
    int             rise_cyc = 0;
    int             ferr_cnt = 0;
    int             popped   = 0;
    logic           prev_valid = 1'b0;
    logic [N*W-1:0] prev_data  = '0;
    logic [N*W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs change at posedge+2, so negedge sees what the next edge samples
    always @(negedge clk) begin
        logic [N*W-1:0] e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_err) ferr_cnt++;
            if (tile_valid && !prev_valid) rise_cyc = cyc;
            if (tile_valid && prev_valid) begin
                checks++;
                if (tile_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: tile_data %h changed from %h while valid",
                             tile_data, prev_data);
                end
            end
            if (tile_valid && tile_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tile: unexpected tile %h", tile_data);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if (tile_data !== e) begin
                        errors++;
                        $display("FAIL tile: got %h expected %h", tile_data, e);
                    end
                end
            end
            prev_valid = tile_valid;
            prev_data  = tile_data;
        end
    end

    task automatic chk(input string name, input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic en, input logic s, input logic d);
        ser_en   = en;
        ser_sync = s;
        ser_data = d;
        tick();
    endtask

    // With gap set, an ignored cycle (en=0, noisy sync/data) precedes each sample
    task automatic sample(input logic s, input logic d, input bit gap);
        if (gap) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        drive(1'b1, s, d);
    endtask

    task automatic send_frame(input logic [W-1:0] v, input bit gap);
        sample(1'b1, 1'b0, gap);
        for (int i = 0; i < W; i++) sample(1'b0, v[i], gap);
    endtask

    task automatic send_tile(input logic [N*W-1:0] t, input bit gap);
        for (int e = 0; e < N; e++) send_frame(t[e*W +: W], gap);
        ser_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int f0;
        rst = 1'b1; ser_en = 1'b0; ser_sync = 1'b0; ser_data = 1'b0;
        tile_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data", tile_data, '0);
        chk("rst_valid", tile_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // Basic tile, continuous strobe
        tile_ready = 1'b1;
        c0 = cyc;
        exp_q.push_back(TA);
        send_tile(TA, 1'b0);
        tick(); tick();
        chk("lat_basic", rise_cyc - c0, 144);
        drain("drain_basic");

        // Gapped strobe
        c0 = cyc;
        exp_q.push_back(TA);
        send_tile(TA, 1'b1);
        tick(); tick();
        chk("lat_gapped", rise_cyc - c0, 288);
        drain("drain_gapped");

        // Backpressure with overflow and ovf_clr priority
        tile_ready = 1'b0;
        exp_q.push_back(TB);
        send_tile(TB, 1'b0);
        tick();
        chk("bp_valid", tile_valid, 1);
        chk("bp_ovf0", overflow, 0);
        send_frame(8'hAA, 1'b0);
        chk("bp_ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        ovf_clr = 1'b0;
        chk("bp_clr_prio", overflow, 0);
        send_frame(8'h55, 1'b0);
        ser_en = 1'b0;
        chk("bp_ovf_again", overflow, 1);
        chk("bp_still_valid", tile_valid, 1);
        tile_ready = 1'b1;
        tick();
        chk("bp_valid_fall", tile_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", overflow, 0);
        drain("drain_bp");

        // Early sync inside element 5
        f0 = ferr_cnt;
        exp_q.push_back(TE);
        for (int e = 0; e < N; e++) begin
            if (e == 5) begin
                sample(1'b1, 1'b0, 1'b0);
                for (int i = 0; i < 4; i++) sample(1'b0, 1'(i % 2), 1'b0);
                send_frame(8'h7F, 1'b0);
            end else begin
                send_frame(TE[e*W +: W], 1'b0);
            end
        end
        ser_en = 1'b0;
        drain("drain_early");
        chk("ferr_once", ferr_cnt - f0, 1);

        // Accept and next sync on the same edge
        tile_ready = 1'b0;
        exp_q.push_back(TD);
        send_tile(TD, 1'b0);
        tick();
        chk("sim_valid", tile_valid, 1);
        tile_ready = 1'b1;
        exp_q.push_back(TE2);
        send_tile(TE2, 1'b0);
        tick(); tick();
        chk("sim_no_ovf", overflow, 0);
        drain("drain_sim");

        // Reset during element 9, bit 3
        for (int e = 0; e < 9; e++) send_frame(TF[e*W +: W], 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sample(1'b0, 1'b1, 1'b0);
        ser_en = 1'b1; ser_sync = 1'b0; ser_data = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mrst_data", tile_data, '0);
        chk("mrst_valid", tile_valid, 0);
        chk("mrst_ferr", frame_err, 0);
        chk("mrst_ovf", overflow, 0);
        ser_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(TG);
        send_tile(TG, 1'b0);
        drain("drain_rst");

        tick(); tick();
        chk("ferr_total", ferr_cnt, 1);
        chk("tiles_popped", popped, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
